// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Single-port word memory behind a valid/ready load/store request channel
//   and a valid/ready response channel. Byte and half stores are done as a
//   read-modify-write so untouched lanes keep their contents. Lanes are
//   big-endian within a word: byte offset 0 is bits [31:24].
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready.
//   The request side is ready only in IDLE. Once asserted, the response is
//   held stable until rsp_ready. The block returns to IDLE on the edge that
//   completes the response, so a new request is accepted no earlier than
//   the following cycle.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous, active-low reset (storage is not cleared)
//   req_valid    request present
//   req_ready    request can be accepted (IDLE only)
//   req_we       1 = store, 0 = load
//   req_size     00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned zero-extend byte/half loads when 1
//   req_addr     byte address
//   req_wdata    right-aligned store data
//   rsp_valid    response present
//   rsp_ready    requester takes response
//   rsp_rdata    extended load data, 0 for stores/errors/no response
//   rsp_err      misaligned, illegal size or out-of-range request
//   dbg_state    current FSM state encoding
module data_mem_responder #(
   parameter int DEPTH = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic [2:0]  dbg_state
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      RD     = 3'd1,
      RMW_RD = 3'd2,
      RMW_WR = 3'd3,
      RESP   = 3'd4
   } state_t;

   state_t state, state_nxt;

   logic [31:0]   mem [DEPTH];

   logic          we_q;
   logic [1:0]    size_q;
   logic          uns_q;
   logic [1:0]    lane_q;
   logic [AW-1:0] idx_q;
   logic [31:0]   wdata_q;
   logic [31:0]   merge_q;
   logic [31:0]   rdata_q;
   logic          err_q;
   logic          ready_en;   // keeps req_ready low until the first edge after reset

   logic          accept;
   logic          req_err;
   logic [31:0]   rd_word;

   // Select the addressed lane(s) and extend to 32 bits.
   function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [1:0] size,
                                                input logic [1:0] lane, input logic uns);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      case (lane)
         2'd0:    b = w[31:24];
         2'd1:    b = w[23:16];
         2'd2:    b = w[15:8];
         default: b = w[7:0];
      endcase
      h = lane[1] ? w[15:0] : w[31:16];
      case (size)
         2'b00:   r = uns ? {24'h0, b} : {{24{b[7]}}, b};
         2'b01:   r = uns ? {16'h0, h} : {{16{h[15]}}, h};
         default: r = w;
      endcase
      return r;
   endfunction

   // Insert right-aligned store data into the addressed lane(s) of the old word.
   function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] wd,
                                               input logic [1:0] size, input logic [1:0] lane);
      logic [31:0] r;
      r = old;
      if (size == 2'b00) begin
         case (lane)
            2'd0:    r[31:24] = wd[7:0];
            2'd1:    r[23:16] = wd[7:0];
            2'd2:    r[15:8]  = wd[7:0];
            default: r[7:0]   = wd[7:0];
         endcase
      end else if (lane[1]) begin
         r[15:0] = wd[15:0];
      end else begin
         r[31:16] = wd[15:0];
      end
      return r;
   endfunction

   assign accept  = req_valid && req_ready;
   // The whole word address is compared so high address bits can never alias.
   assign req_err = (req_size == 2'b11) ||
                    (req_size == 2'b01 && req_addr[0]) ||
                    (req_size == 2'b10 && req_addr[1:0] != 2'b00) ||
                    (req_addr[31:2] >= 30'(DEPTH));
   assign rd_word = mem[idx_q];

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (accept) begin
               if (req_err)                state_nxt = RESP;
               else if (!req_we)           state_nxt = RD;
               else if (req_size == 2'b10) state_nxt = RMW_WR;
               else                        state_nxt = RMW_RD;
            end
         end
         RD:      state_nxt = RESP;
         RMW_RD:  state_nxt = RMW_WR;
         RMW_WR:  state_nxt = RESP;
         RESP:    if (rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs
   always_comb begin
      req_ready = (state == IDLE) && ready_en;
      rsp_valid = (state == RESP);
      rsp_rdata = (state == RESP) ? rdata_q : 32'h0;
      rsp_err   = (state == RESP) ? err_q : 1'b0;
      dbg_state = state;
   end

   // Request capture and datapath registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ready_en <= 1'b0;
         we_q     <= 1'b0;
         size_q   <= 2'b00;
         uns_q    <= 1'b0;
         lane_q   <= 2'b00;
         idx_q    <= '0;
         wdata_q  <= 32'h0;
         merge_q  <= 32'h0;
         rdata_q  <= 32'h0;
         err_q    <= 1'b0;
      end else begin
         ready_en <= 1'b1;
         if (accept) begin
            we_q    <= req_we;
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            lane_q  <= req_addr[1:0];
            idx_q   <= req_addr[AW+1:2];
            wdata_q <= req_wdata;
            rdata_q <= 32'h0;
            err_q   <= req_err;
         end
         if (state == RD)     rdata_q <= load_extract(rd_word, size_q, lane_q, uns_q);
         if (state == RMW_RD) merge_q <= store_merge(rd_word, wdata_q, size_q, lane_q);
      end
   end

   // Storage write. Reset forces the FSM out of RMW_WR, so an aborted store
   // never reaches this point.
   always_ff @(posedge clk) begin
      if (state == RMW_WR && we_q)
         mem[idx_q] <= (size_q == 2'b10) ? wdata_q : merge_q;
   end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, meaning number of 32-bit words in internal storage (power of two).
REQ-002 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req_valid  input  1  load/store request present.
REQ-005 SHALL have port req_ready  output  1  block can accept a request this cycle.
REQ-006 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-007 SHALL have port req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-008 SHALL have port req_unsigned  input  1  zero-extend loads (lbu/lhu) when 1, sign-extend when 0.
REQ-009 SHALL have port req_addr  input  32  byte address.
REQ-010 SHALL have port req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-011 SHALL have port rsp_valid  output  1  response available.
REQ-012 SHALL have port rsp_ready  input  1  requester accepts response.
REQ-013 SHALL have port rsp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-014 SHALL have port rsp_err  output  1  misaligned, illegal size, or out-of-range request.

Function
REQ-015 SHALL use big-endian lane mapping: addr[1:0]=0 -> bits [31:24], 1 -> [23:16], 2 -> [15:8], 3 -> [7:0]; half at addr[1:0]=0 -> [31:16], 2 -> [15:0].
REQ-016 SHALL implement FSM states IDLE, RD, RMW_RD, RMW_WR, RESP.
REQ-017 SHALL assert req_ready only in IDLE; a request is accepted when req_valid && req_ready, capturing all req_* fields.
REQ-018 SHALL detect error at acceptance: req_size=11, half with addr[0]=1, word with addr[1:0]!=0, or addr[31:2] >= DEPTH; error goes IDLE -> RESP with rsp_err=1, no storage access.
REQ-019 SHALL, for a legal load, go IDLE -> RD -> RESP; rsp_valid asserts 2 cycles after acceptance.
REQ-020 SHALL, for a legal word store, go IDLE -> RMW_WR -> RESP, writing the full word in RMW_WR; rsp_valid 2 cycles after acceptance.
REQ-021 SHALL, for a legal byte/half store, go IDLE -> RMW_RD -> RMW_WR -> RESP, merging req_wdata into the addressed lane(s) and preserving other lanes; rsp_valid 3 cycles after acceptance.
REQ-022 SHALL hold rsp_valid, rsp_rdata, rsp_err stable in RESP until rsp_ready=1, then return to IDLE the following cycle (no back-to-back accept in the same cycle as response completion).
REQ-023 SHALL sign- or zero-extend byte/half load data to 32 bits per req_unsigned; req_unsigned ignored for word loads and stores.
REQ-024 SHALL index storage with addr[log2(DEPTH)+1:2]; no wrap-around, upper address bits beyond range trigger REQ-018.
REQ-025 SHALL drive rsp_rdata=0 and rsp_err=0 whenever rsp_valid=0.

Reset
REQ-026 SHALL, while rst=0, force state IDLE, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0; req_ready rises the first clock after rst deasserts.
REQ-027 SHALL NOT clear storage contents on reset.
REQ-028 SHALL abort any in-flight request on reset; a store reset before its RMW_WR edge SHALL leave the word unchanged.

Verification
REQ-029 Word store 0xDEADBEEF @0x10, then lw @0x10 -> store rsp at +2 cycles err=0; load rsp_rdata=0xDEADBEEF at +2 cycles.
REQ-030 After REQ-029, sb 0x55 @0x11, then lw @0x10 -> 0xDE55BEEF; store response at +3 cycles.
REQ-031 lb @0x13 on word 0xDE55BE80 -> 0xFFFFFF80; lbu @0x13 -> 0x00000080; lh @0x12 -> 0xFFFFBE80; lhu @0x12 -> 0x0000BE80.
REQ-032 lh @0x11, lw @0x12, size=11 @0x10, lw @(DEPTH*4) -> each rsp_err=1, rsp_rdata=0, storage unchanged, rsp at +1 cycle.
REQ-033 Hold rsp_ready=0 for 5 cycles after load -> rsp_valid/rsp_rdata stable, req_ready=0 throughout; accept completes on rsp_ready=1.
REQ-034 sh 0x1234 @0x10 with rst pulsed low during RMW_RD -> all outputs 0 immediately, lw @0x10 afterwards returns pre-store value.
